sudoku_engine_n: RTL and testbench

SUDOKU_ENGINE_N -- requirements
Module: sudoku_engine_n

---
 rtl/sudoku_engine_n.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sudoku_engine_n.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_engine_n.sv
// Sudoku game engine: streamed puzzle/solution load, cursor-driven play,
// mistake limit and a one-cell-per-cycle completion check.
module sudoku_engine_n #(
    parameter int BOX          = 3,
    parameter int MAX_MISTAKES = 3,
    localparam int N  = BOX * BOX,
    localparam int C  = N * N,
    localparam int VW = $clog2(N + 1),
    localparam int IW = $clog2(N),
    localparam int KW = $clog2(C + 1),
    localparam int MW = (MAX_MISTAKES > 0) ? $clog2(MAX_MISTAKES + 1) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_load,
    input  logic          ld_valid,
    input  logic [VW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd_op,
    input  logic [VW-1:0] cmd_num,
    input  logic [IW-1:0] rd_x,
    input  logic [IW-1:0] rd_y,
    output logic [VW-1:0] rd_val,
    output logic          rd_fixed,
    output logic          rd_match,
    output logic [IW-1:0] cur_x,
    output logic [IW-1:0] cur_y,
    output logic [VW-1:0] cur_val,
    output logic          engine_ready,
    output logic          game_won,
    output logic          game_lost,
    output logic [MW-1:0] mistakes,
    output logic [KW-1:0] filled
);

    localparam int AW = $clog2(C);
    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [AW-1:0] CLAST = AW'(C - 1);
    localparam logic [VW-1:0] NV    = VW'(N);
    localparam logic [MW-1:0] MSAT  =
        (MAX_MISTAKES > 0) ? MW'(MAX_MISTAKES) : {MW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_INIT,
        S_LOAD_SOL,
        S_PLAY,
        S_CHECK,
        S_OVER
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_UP,
        OP_DOWN,
        OP_LEFT,
        OP_RIGHT,
        OP_ENTER,
        OP_CLEAR,
        OP_WRITE
    } op_t;

    state_t state, state_nxt;
    op_t    op;

    logic [VW-1:0] grid [C];
    logic [VW-1:0] sol  [C];
    logic [C-1:0]  fixed;

    logic [AW-1:0] ld_cnt;
    logic [AW-1:0] scan_cnt;
    logic          scan_ok;

    logic          beat;
    logic          ld_last;
    logic [VW-1:0] ld_val;
    logic          cmd_go;
    logic [AW-1:0] cur_idx;
    logic          num_ok;
    logic          wr_ok;
    logic          wr_bad;
    logic          clr_ok;
    logic [MW-1:0] mis_inc;
    logic          lose_now;
    logic          scan_last;
    logic          chk_eq;
    logic          rd_in;
    logic [AW-1:0] rd_idx;

    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [VW-1:0] g_data;
    logic          g_old_nz;
    logic          g_new_nz;

    function automatic logic [AW-1:0] cell_idx(
        input logic [IW-1:0] x,
        input logic [IW-1:0] y
    );
        return AW'(int'(y) * N + int'(x));
    endfunction

    assign op       = op_t'(cmd_op);
    assign ld_ready = (state == S_LOAD_INIT) || (state == S_LOAD_SOL);
    assign beat     = ld_valid && ld_ready && !start_load;
    assign ld_val   = (ld_data > NV) ? '0 : ld_data;
    assign ld_last  = (ld_cnt == CLAST);

    assign cmd_go  = cmd_valid && (state == S_PLAY) && !start_load;
    assign cur_idx = cell_idx(cur_x, cur_y);
    assign num_ok  = (cmd_num != '0) && (cmd_num <= NV);
    assign wr_ok   = cmd_go && (op == OP_WRITE) && num_ok
                     && !fixed[cur_idx];
    assign wr_bad  = wr_ok && (cmd_num != sol[cur_idx])
                     && (cmd_num != grid[cur_idx]);
    assign clr_ok  = cmd_go && (op == OP_CLEAR) && !fixed[cur_idx];
    assign mis_inc = mistakes + MW'(1);
    assign lose_now = (MAX_MISTAKES > 0) && wr_bad && (mis_inc == MSAT);

    assign scan_last = (scan_cnt == CLAST);
    assign chk_eq    = (grid[scan_cnt] == sol[scan_cnt]);

    assign rd_in    = (int'(rd_x) < N) && (int'(rd_y) < N);
    assign rd_idx   = rd_in ? cell_idx(rd_x, rd_y) : '0;
    assign rd_val   = rd_in ? grid[rd_idx] : '0;
    assign rd_fixed = rd_in && fixed[rd_idx];
    assign rd_match = rd_in && (grid[rd_idx] == sol[rd_idx]);

    assign cur_val      = grid[cur_idx];
    assign engine_ready = (state == S_PLAY);

    // Single grid write port shared by the loader and play commands,
    // so the filled count can be kept exact from old/new values.
    always_comb begin
        g_we   = 1'b0;
        g_addr = cur_idx;
        g_data = cmd_num;
        if (beat && (state == S_LOAD_INIT)) begin
            g_we   = 1'b1;
            g_addr = ld_cnt;
            g_data = ld_val;
        end else if (wr_ok) begin
            g_we = 1'b1;
        end else if (clr_ok) begin
            g_we   = 1'b1;
            g_data = '0;
        end
        g_old_nz = (grid[g_addr] != '0);
        g_new_nz = (g_data != '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: ;
            S_LOAD_INIT: begin
                if (beat && ld_last) state_nxt = S_LOAD_SOL;
            end
            S_LOAD_SOL: begin
                if (beat && ld_last) state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (cmd_go && (op == OP_ENTER)) state_nxt = S_CHECK;
                else if (lose_now)               state_nxt = S_OVER;
            end
            S_CHECK: begin
                if (scan_last)
                    state_nxt = (scan_ok && chk_eq) ? S_OVER : S_PLAY;
            end
            S_OVER: ;
            default: state_nxt = S_IDLE;
        endcase
        if (start_load) state_nxt = S_LOAD_INIT;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C; i++) begin
                grid[i] <= '0;
                sol[i]  <= '0;
            end
            fixed     <= '0;
            ld_cnt    <= '0;
            scan_cnt  <= '0;
            scan_ok   <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
            mistakes  <= '0;
            filled    <= '0;
            game_won  <= 1'b0;
            game_lost <= 1'b0;
        end else begin
            if (g_we) grid[g_addr] <= g_data;
            if (g_we && g_new_nz && !g_old_nz)
                filled <= filled + KW'(1);
            else if (g_we && !g_new_nz && g_old_nz)
                filled <= filled - KW'(1);

            if (start_load) begin
                ld_cnt    <= '0;
                cur_x     <= '0;
                cur_y     <= '0;
                mistakes  <= '0;
                game_won  <= 1'b0;
                game_lost <= 1'b0;
            end else begin
                case (state)
                    S_LOAD_INIT: begin
                        if (beat) begin
                            fixed[ld_cnt] <= (ld_val != '0);
                            ld_cnt <= ld_last ? '0 : ld_cnt + AW'(1);
                        end
                    end
                    S_LOAD_SOL: begin
                        if (beat) begin
                            sol[ld_cnt] <= ld_val;
                            ld_cnt <= ld_last ? '0 : ld_cnt + AW'(1);
                            if (ld_last) begin
                                cur_x     <= '0;
                                cur_y     <= '0;
                                mistakes  <= '0;
                                game_won  <= 1'b0;
                                game_lost <= 1'b0;
                            end
                        end
                    end
                    S_PLAY: begin
                        if (cmd_go) begin
                            case (op)
                                OP_UP:
                                    cur_y <= (cur_y == '0) ? LAST
                                             : cur_y - IW'(1);
                                OP_DOWN:
                                    cur_y <= (cur_y == LAST) ? '0
                                             : cur_y + IW'(1);
                                OP_LEFT:
                                    cur_x <= (cur_x == '0) ? LAST
                                             : cur_x - IW'(1);
                                OP_RIGHT:
                                    cur_x <= (cur_x == LAST) ? '0
                                             : cur_x + IW'(1);
                                OP_ENTER: begin
                                    scan_cnt <= '0;
                                    scan_ok  <= 1'b1;
                                end
                                OP_WRITE: begin
                                    if (wr_bad && (mistakes != MSAT))
                                        mistakes <= mis_inc;
                                    if (lose_now) game_lost <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_CHECK: begin
                        scan_cnt <= scan_cnt + AW'(1);
                        scan_ok  <= scan_ok && chk_eq;
                        // Loss from a failed check stays set until reload.
                        if (scan_last) begin
                            if (scan_ok && chk_eq) game_won  <= 1'b1;
                            else                   game_lost <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sudoku_engine_n.sv
// Scoreboard bench for sudoku_engine_n: a 9x9 (BOX=3) and a 4x4 (BOX=2)
// engine share the input buses; a per-engine model predicts every output.
module tb_sudoku_engine_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       ld_valid = 1'b0, cmd_valid = 1'b0;
    logic [3:0] ld_data = '0, cmd_num = '0, rd_x = '0, rd_y = '0;
    logic [2:0] cmd_op = '0;

    logic       a_ldr, a_rfix, a_rmat, a_rdy, a_won, a_lost;
    logic [3:0] a_rval, a_cx, a_cy, a_cv;
    logic [1:0] a_mis;
    logic [6:0] a_fill;

    logic       b_ldr, b_rfix, b_rmat, b_rdy, b_won, b_lost;
    logic [2:0] b_rval, b_cv;
    logic [1:0] b_cx, b_cy, b_mis;
    logic [4:0] b_fill;

    sudoku_engine_n #(.BOX(3), .MAX_MISTAKES(3)) dut_a (
        .clk(clk), .reset(reset), .start_load(start_a),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(a_ldr),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_num(cmd_num),
        .rd_x(rd_x), .rd_y(rd_y), .rd_val(a_rval),
        .rd_fixed(a_rfix), .rd_match(a_rmat),
        .cur_x(a_cx), .cur_y(a_cy), .cur_val(a_cv),
        .engine_ready(a_rdy), .game_won(a_won), .game_lost(a_lost),
        .mistakes(a_mis), .filled(a_fill)
    );

    sudoku_engine_n #(.BOX(2), .MAX_MISTAKES(3)) dut_b (
        .clk(clk), .reset(reset), .start_load(start_b),
        .ld_valid(ld_valid), .ld_data(ld_data[2:0]), .ld_ready(b_ldr),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_num(cmd_num[2:0]),
        .rd_x(rd_x[1:0]), .rd_y(rd_y[1:0]), .rd_val(b_rval),
        .rd_fixed(b_rfix), .rd_match(b_rmat),
        .cur_x(b_cx), .cur_y(b_cy), .cur_val(b_cv),
        .engine_ready(b_rdy), .game_won(b_won), .game_lost(b_lost),
        .mistakes(b_mis), .filled(b_fill)
    );

    typedef struct {
        int d;
        int cx, cy, cv, fl, mis, won, lost, rdy;
    } snap_t;

    snap_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    int mg[2][81];
    int ms[2][81];
    bit mf[2][81];
    int mx[2], my[2], mmis[2];
    bit mwon[2], mlost[2], mplay[2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int nn(input int d);
        return (d != 0) ? 4 : 9;
    endfunction

    function automatic int sol_of(input int d, input int k);
        int n, b, r, c;
        n = nn(d);
        b = (d != 0) ? 2 : 3;
        r = k / n;
        c = k % n;
        return ((r * b + r / b + c) % n) + 1;
    endfunction

    function automatic int init_of(input int d, input int k);
        if (k % ((d != 0) ? 4 : 3) == 0) return sol_of(d, k);
        if (k % 5 == 2) return 15;
        return 0;
    endfunction

    function automatic int count(input int d);
        int c = 0;
        for (int k = 0; k < nn(d) * nn(d); k++)
            if (mg[d][k] != 0) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 81; k++) begin
                mg[d][k] = 0;
                ms[d][k] = 0;
                mf[d][k] = 1'b0;
            end
            mx[d] = 0; my[d] = 0; mmis[d] = 0;
            mwon[d] = 1'b0; mlost[d] = 1'b0; mplay[d] = 1'b0;
        end
    endtask

    task automatic model_load(input int d);
        int v;
        for (int k = 0; k < nn(d) * nn(d); k++) begin
            v = init_of(d, k);
            if (v > nn(d)) v = 0;
            mg[d][k] = v;
            mf[d][k] = (v != 0);
            ms[d][k] = sol_of(d, k);
        end
        mx[d] = 0; my[d] = 0; mmis[d] = 0;
        mwon[d] = 1'b0; mlost[d] = 1'b0; mplay[d] = 1'b1;
    endtask

    task automatic model_cmd(input int d, input int op, input int num_in);
        int n, k, num;
        n = nn(d);
        k = my[d] * n + mx[d];
        num = num_in & ((d != 0) ? 7 : 15);
        if (!mplay[d]) return;
        case (op)
            1: my[d] = (my[d] == 0) ? n - 1 : my[d] - 1;
            2: my[d] = (my[d] == n - 1) ? 0 : my[d] + 1;
            3: mx[d] = (mx[d] == 0) ? n - 1 : mx[d] - 1;
            4: mx[d] = (mx[d] == n - 1) ? 0 : mx[d] + 1;
            6: if (!mf[d][k]) mg[d][k] = 0;
            7: begin
                if (!mf[d][k] && num >= 1 && num <= n) begin
                    if (num != ms[d][k] && num != mg[d][k]) begin
                        mmis[d]++;
                        if (mmis[d] == 3) begin
                            mlost[d] = 1'b1;
                            mplay[d] = 1'b0;
                        end
                    end
                    mg[d][k] = num;
                end
            end
            default: ;
        endcase
    endtask

    task automatic push(input int d);
        snap_t s;
        s.d = d;
        s.cx = mx[d];
        s.cy = my[d];
        s.cv = mg[d][my[d] * nn(d) + mx[d]];
        s.fl = count(d);
        s.mis = mmis[d];
        s.won = mwon[d];
        s.lost = mlost[d];
        s.rdy = mplay[d];
        sb.push_back(s);
    endtask

    task automatic drain();
        snap_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (s.d == 0) begin
                check("a.cur_x", a_cx, s.cx);
                check("a.cur_y", a_cy, s.cy);
                check("a.cur_val", a_cv, s.cv);
                check("a.filled", a_fill, s.fl);
                check("a.mistakes", a_mis, s.mis);
                check("a.won", a_won, s.won);
                check("a.lost", a_lost, s.lost);
                check("a.ready", a_rdy, s.rdy);
                check("a.ld_ready", a_ldr, 0);
            end else begin
                check("b.cur_x", b_cx, s.cx);
                check("b.cur_y", b_cy, s.cy);
                check("b.cur_val", b_cv, s.cv);
                check("b.filled", b_fill, s.fl);
                check("b.mistakes", b_mis, s.mis);
                check("b.won", b_won, s.won);
                check("b.lost", b_lost, s.lost);
                check("b.ready", b_rdy, s.rdy);
                check("b.ld_ready", b_ldr, 0);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        push(0);
        push(1);
        drain();
    endtask

    task automatic stream(input int d, input int beats);
        int c;
        c = nn(d) * nn(d);
        @(negedge clk);
        if (d == 0) start_a = 1'b1;
        else        start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int k = 0; k < beats; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ld_valid = 1'b1;
            ld_data = 4'((k < c) ? init_of(d, k) : sol_of(d, k - c));
            if (k == 0 || k == 2 * c - 1)
                check("ld_ready", (d == 0) ? a_ldr : b_ldr, 1);
            @(negedge clk);
            ld_valid = 1'b0;
        end
    endtask

    task automatic load(input int d);
        stream(d, 2 * nn(d) * nn(d));
        model_load(d);
        push(0);
        push(1);
        drain();
    endtask

    task automatic cmd(input int op, input int num);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'(op);
        cmd_num = 4'(num);
        model_cmd(0, op, num);
        model_cmd(1, op, num);
        push(0);
        push(1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = '0;
        drain();
    endtask

    task automatic enter(input int d);
        int  busy;
        bit  ok;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = '0;
        busy = 0;
        while (!((d == 0) ? a_rdy : b_rdy) && !((d == 0) ? a_won : b_won)
               && busy < 300) begin
            @(negedge clk);
            busy++;
        end
        check("check_cycles", busy, nn(d) * nn(d));
        ok = 1'b1;
        for (int k = 0; k < nn(d) * nn(d); k++)
            if (mg[d][k] != ms[d][k]) ok = 1'b0;
        if (ok) begin
            mwon[d] = 1'b1;
            mplay[d] = 1'b0;
        end else begin
            mlost[d] = 1'b1;
        end
        push(0);
        push(1);
        drain();
    endtask

    task automatic rd_sweep(input int d);
        int n;
        n = nn(d);
        for (int k = 0; k < n * n; k++) begin
            rd_x = 4'(k % n);
            rd_y = 4'(k / n);
            #1;
            if (d == 0) begin
                check("a.rd_val", a_rval, mg[0][k]);
                check("a.rd_fixed", a_rfix, mf[0][k]);
                check("a.rd_match", a_rmat, mg[0][k] == ms[0][k]);
            end else begin
                check("b.rd_val", b_rval, mg[1][k]);
                check("b.rd_fixed", b_rfix, mf[1][k]);
                check("b.rd_match", b_rmat, mg[1][k] == ms[1][k]);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push(0);
        push(1);
        drain();

        load(0);
        rd_sweep(0);
        rd_x = 4'd9;
        rd_y = 4'd2;
        #1;
        check("a.rd_val_oob", a_rval, 0);
        check("a.rd_fixed_oob", a_rfix, 0);
        check("a.rd_match_oob", a_rmat, 0);

        cmd(3, 0);
        cmd(1, 0);
        cmd(4, 0);
        cmd(2, 0);

        cmd(7, 5);
        cmd(4, 0);
        cmd(7, sol_of(0, 1));
        cmd(6, 0);
        cmd(7, 0);
        cmd(7, 10);
        cmd(3, 0);

        for (int y = 0; y < 9; y++) begin
            for (int x = 0; x < 9; x++) begin
                if (!mf[0][y * 9 + x])
                    cmd(7, (y * 9 + x == 40) ? (ms[0][40] % 9) + 1
                                             : ms[0][y * 9 + x]);
                cmd(4, 0);
            end
            cmd(2, 0);
        end
        rd_sweep(0);
        enter(0);

        repeat (4) cmd(4, 0);
        repeat (4) cmd(2, 0);
        cmd(7, sol_of(0, 40));
        enter(0);
        cmd(4, 0);

        load(0);
        cmd(4, 0);
        cmd(7, 3);
        cmd(7, 4);
        cmd(7, 5);
        cmd(7, 2);

        stream(1, 5);
        do_reset();
        load(1);
        rd_sweep(1);
        cmd(3, 0);
        cmd(4, 0);
        cmd(1, 0);
        cmd(2, 0);
        cmd(4, 0);
        cmd(7, 5);
        cmd(7, sol_of(1, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
